// File: rtl/adder_pkg.sv
// Shared constants for the pipelined adder: operation encodings and default geometry.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_STAGES = 4;

endpackage : adder_pkg

// File: rtl/adder_slice.sv
// Combinational ripple-carry slice; also exposes the carry into its top bit for overflow.
module adder_slice #(
  parameter int unsigned SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          c_msb_in
);

  logic [SW:0] c;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(SW); i++) begin
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign sum      = a ^ b ^ c[SW-1:0];
  assign cout     = c[SW];
  assign c_msb_in = c[SW-1];

endmodule : adder_slice

// File: rtl/pipe_adder.sv
// Carry-pipelined adder/subtractor: one SW-bit slice per stage, operands skewed alongside,
// valid/ready handshake with a single global advance enable.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SW = WIDTH / STAGES;

  logic adv;

  // Stage inputs: index 0 fed from the ports, index k from the stage k-1 registers.
  logic [WIDTH-1:0]  in_a [STAGES];
  logic [WIDTH-1:0]  in_b [STAGES];
  logic [WIDTH-1:0]  in_s [STAGES];
  logic [STAGES-1:0] in_c;
  logic [STAGES-1:0] in_v;

  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;

  logic [WIDTH-1:0]  slice_sum;
  logic [STAGES-1:0] slice_co;
  logic [STAGES-1:0] slice_cmsb;
  logic [WIDTH-1:0]  nxt_s [STAGES];
  logic              unused_cmsb;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    in_a[0] = a;
    in_b[0] = (op == OP_SUB) ? ~b : b;
    in_c[0] = (op == OP_SUB) ? 1'b1 : cin;
    in_s[0] = '0;
    in_v[0] = in_valid;
    for (int k = 1; k < int'(STAGES); k++) begin
      in_a[k] = r_a[k-1];
      in_b[k] = r_b[k-1];
      in_c[k] = r_c[k-1];
      in_s[k] = r_s[k-1];
      in_v[k] = r_v[k-1];
    end
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    adder_slice #(.SW(SW)) u_slice (
      .a        (in_a[k][k*SW +: SW]),
      .b        (in_b[k][k*SW +: SW]),
      .cin      (in_c[k]),
      .sum      (slice_sum[k*SW +: SW]),
      .cout     (slice_co[k]),
      .c_msb_in (slice_cmsb[k])
    );
  end

  // Merge each stage's fresh slice into the partial result carried forward.
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      nxt_s[k]              = in_s[k];
      nxt_s[k][k*SW +: SW]  = slice_sum[k*SW +: SW];
    end
  end

  // Only the top stage's carry-into-MSB feeds ovf.
  assign unused_cmsb = ^slice_cmsb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
      r_c  <= '0;
      r_v  <= '0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        r_a[k] <= in_a[k];
        r_b[k] <= in_b[k];
        r_s[k] <= nxt_s[k];
      end
      r_c  <= slice_co;
      r_v  <= in_v;
      ovf  <= slice_co[STAGES-1] ^ slice_cmsb[STAGES-1];
      zero <= (nxt_s[STAGES-1] == '0);
    end
  end

  assign sum       = r_s[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign out_valid = r_v[STAGES-1];

endmodule : pipe_adder

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 4, pipeline depth; SHALL be >= 1 and SHALL divide WIDTH exactly (slice width SW = WIDTH/STAGES).
REQ-003 Port list SHALL be exactly as follows:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block accepts beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when op=SUB.
- op  in  1  0=ADD, 1=SUB.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of MSB; for SUB, 1 means no borrow.
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.

Function
REQ-004 ADD SHALL compute a + b + cin; SUB SHALL compute a + ~b + 1, with cin ignored; sum SHALL be the result mod 2^WIDTH.
REQ-005 Stage k (0..STAGES-1) SHALL add bits [k*SW +: SW] using the carry registered by stage k-1; stage 0 SHALL use the effective carry-in.
REQ-006 Upper operand slices SHALL be skewed through registers so each slice meets its carry in the correct cycle; completed lower result slices SHALL be carried forward alongside.
REQ-007 Latency SHALL be exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid, with no stall.
REQ-008 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-009 Pipeline SHALL advance on every edge where adv = !out_valid | out_ready; in_ready SHALL equal adv (combinational).
REQ-010 When adv=0, every stage register, sum, cout, ovf, zero and out_valid SHALL hold stable.
REQ-011 Beats SHALL leave in acceptance order; none dropped or duplicated.
REQ-012 A per-stage valid bit SHALL shift with the data; bubbles SHALL propagate as out_valid=0.
REQ-013 ovf SHALL equal carry into MSB XOR carry out of MSB.
REQ-014 zero SHALL be registered with the final stage.
REQ-015 cout, ovf and zero SHALL be meaningful only while out_valid=1.
REQ-016 in_valid=1 with in_ready=0 SHALL NOT capture the offered beat.
REQ-017 STAGES=1 SHALL degenerate to a single registered full-width adder with the same handshake.

Reset
REQ-018 rst=1 SHALL asynchronously clear all stage valid bits, out_valid, sum, cout, ovf and zero to 0.
REQ-019 Reset mid-operation SHALL discard all in-flight beats.
REQ-020 The first accepting edge after rst deasserts SHALL produce a result STAGES cycles later.
REQ-021 in_ready SHALL be 1 during and after reset, since out_valid=0.

Structure
REQ-022 Shared package adder_pkg SHALL hold: op encodings OP_ADD=1'b0 and OP_SUB=1'b1; default constants for WIDTH (32) and STAGES (4).
REQ-023 One sub-module adder_slice SHALL be used:
- parameter SW.
- inputs a, b, cin; outputs sum, cout, c_msb_in (carry into top bit).
- purely combinational ripple; instantiated once per stage via generate.

Verification
REQ-024 ADD, WIDTH=32, STAGES=4, a=0xFFFFFFFF, b=0x00000001, cin=0:
- after 4 cycles: sum=0, cout=1, zero=1, ovf=0.
REQ-025 ADD a=0x7FFFFFFF, b=1:
- sum=0x80000000, ovf=1, cout=0.
REQ-026 SUB a=0, b=1, cin=1:
- sum=0xFFFFFFFF, cout=0, ovf=0, zero=0; cin has no effect.
REQ-027 Back-to-back stream of 8 beats with out_ready low on cycles 5-7:
- outputs hold stable and in_ready=0 during stall;
- all 8 results correct and in order, none lost.
REQ-028 Reset asserted with 3 beats in flight:
- out_valid drops immediately, asynchronously;
- no stale result appears after release;
- next beat emerges after exactly 4 cycles.
REQ-029 STAGES=1 and STAGES=8 (WIDTH=32):
- 1000 random ADD/SUB beats with random in_valid/out_ready;
- results match reference arithmetic, latency equals STAGES.
